// File: rtl/exception_sequencer.sv
// -----------------------------------------------------------------------------
// exception_sequencer
//
// Multicycle exception-entry controller that sits beside the main control FSM.
// On an invalid-opcode, overflow or divide-by-zero event it saves EPC, steers
// the memory address mux to the matching fixed vector (NoOp 253, Overflow 254,
// Div0 255), waits out the memory read latency and finally loads PC with the
// zero-extended vector byte. While busy is high its src_add_mem overrides the
// main FSM's select.
//
// Parameters:
//   MEM_LATENCY  cycles from a stable address to valid mem_data_out (1..15)
//   PC_INC       amount subtracted from the captured PC to form EPC
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   exc_noop      invalid opcode detected (level, sampled in IDLE)
//   exc_overflow  ALU overflow detected
//   exc_div0      division by zero detected
//   pc_cur        current (already incremented) PC
//   mem_data_out  memory read data
//   src_add_mem   address-source select: 000 PC, 010 NoOp, 011 Ovf, 100 Div0
//   busy          sequencer owns the address select and PC/EPC writes
//   epc_write     one-cycle EPC write strobe
//   epc_value     EPC data (hold value when strobe is low)
//   pc_write      one-cycle PC write strobe
//   pc_value      new PC data (hold value when strobe is low)
//   exc_cause     latched cause: 0 none, 1 NoOp, 2 Overflow, 3 Div0
//   done          one-cycle completion pulse
// -----------------------------------------------------------------------------
module exception_sequencer #(
    parameter int          MEM_LATENCY = 2,
    parameter int unsigned PC_INC      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_noop,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_cur,
    input  logic [31:0] mem_data_out,
    output logic [2:0]  src_add_mem,
    output logic        busy,
    output logic        epc_write,
    output logic [31:0] epc_value,
    output logic        pc_write,
    output logic [31:0] pc_value,
    output logic [1:0]  exc_cause,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_NOOP = 2'd1;
    localparam logic [1:0] CAUSE_OVF  = 2'd2;
    localparam logic [1:0] CAUSE_DIV0 = 2'd3;

    localparam logic [2:0] SRC_PC   = 3'b000;
    localparam logic [2:0] SRC_NOOP = 3'b010;
    localparam logic [2:0] SRC_OVF  = 3'b011;
    localparam logic [2:0] SRC_DIV0 = 3'b100;

    // WAIT leaves on the cycle the counter reads zero, so loading
    // MEM_LATENCY-1 gives exactly MEM_LATENCY WAIT cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [1:0]  cause_reg, cause_next;
    logic [31:0] pc_lat_reg, pc_lat_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] epc_value_reg;
    logic [31:0] pc_value_reg;
    logic [2:0]  vector_code;
    logic        any_exc;

    // Only the low byte of the vector word is used as the new PC.
    logic unused_mem_bits;
    assign unused_mem_bits = ^mem_data_out[31:8];

    assign any_exc = exc_noop | exc_overflow | exc_div0;

    always_comb begin
        unique case (cause_reg)
            CAUSE_NOOP: vector_code = SRC_NOOP;
            CAUSE_OVF:  vector_code = SRC_OVF;
            CAUSE_DIV0: vector_code = SRC_DIV0;
            default:    vector_code = SRC_PC;
        endcase
    end

    // Next-state and Moore outputs
    always_comb begin
        state_next  = state_reg;
        cause_next  = cause_reg;
        pc_lat_next = pc_lat_reg;
        cnt_next    = cnt_reg;
        busy        = 1'b0;
        src_add_mem = SRC_PC;
        epc_write   = 1'b0;
        pc_write    = 1'b0;
        done        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (any_exc) begin
                    // Div0 > Overflow > NoOp when several fire together.
                    if (exc_div0) begin
                        cause_next = CAUSE_DIV0;
                    end else if (exc_overflow) begin
                        cause_next = CAUSE_OVF;
                    end else begin
                        cause_next = CAUSE_NOOP;
                    end
                    pc_lat_next = pc_cur;
                    state_next  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy        = 1'b1;
                src_add_mem = vector_code;
                epc_write   = 1'b1;
                cnt_next    = CNT_LOAD;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                busy        = 1'b1;
                src_add_mem = vector_code;
                if (cnt_reg == 4'd0) begin
                    state_next = S_LOAD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                src_add_mem = vector_code;
                pc_write    = 1'b1;
                state_next  = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cause_reg     <= CAUSE_NONE;
            pc_lat_reg    <= 32'd0;
            cnt_reg       <= 4'd0;
            epc_value_reg <= 32'd0;
            pc_value_reg  <= 32'd0;
        end else begin
            state_reg  <= state_next;
            cause_reg  <= cause_next;
            pc_lat_reg <= pc_lat_next;
            cnt_reg    <= cnt_next;
            // EPC is registered on entry so it is already valid in CAPTURE.
            if (state_reg == S_IDLE && state_next == S_CAPTURE) begin
                epc_value_reg <= pc_lat_next - 32'(PC_INC);
            end
            // The last WAIT cycle is MEM_LATENCY cycles after the vector
            // address first appeared, so the read data is valid here.
            if (state_reg == S_WAIT && cnt_reg == 4'd0) begin
                pc_value_reg <= {24'd0, mem_data_out[7:0]};
            end
        end
    end

    assign epc_value = epc_value_reg;
    assign pc_value  = pc_value_reg;
    assign exc_cause = cause_reg;

endmodule

// File: tb/tb_exception_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exception_sequencer
//
// Three sequencer instances with MEM_LATENCY 2, 1 and 5, each with its own
// latency-accurate vector memory model. Stimulus pushes the hand-computed
// expected sequence into a scoreboard queue; a monitor compares strobes,
// data, select, cause and busy length whenever a DUT presents them.
// -----------------------------------------------------------------------------
module tb_exception_sequencer;

    typedef struct {
        int          inst;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic [31:0] pcv;
        int          gap;   // required IDLE cycles before CAPTURE, -1 = any
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a  [3];
    logic        noop_a [3];
    logic        ovf_a  [3];
    logic        div0_a [3];
    logic [31:0] pc_a   [3];
    logic [2:0]  src_a  [3];
    logic        busy_a [3];
    logic        epcw_a [3];
    logic [31:0] epcv_a [3];
    logic        pcw_a  [3];
    logic [31:0] pcv_a  [3];
    logic [1:0]  cause_a[3];
    logic        done_a [3];

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
    endfunction

    function automatic logic [2:0] code_of(input logic [1:0] c);
        case (c)
            2'd1:    return 3'b010;
            2'd2:    return 3'b011;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 1 : 5);
        logic [2:0]  addr_pipe [L];
        logic [31:0] mem_data;

        // Data for an address is visible L cycles after the address appears.
        always @(posedge clk) begin
            addr_pipe[0] <= src_a[gi];
            for (int k = 1; k < L; k++) addr_pipe[k] <= addr_pipe[k-1];
        end

        always_comb begin
            case (addr_pipe[L-1])
                3'b010:  mem_data = 32'hDEADBE11;  // address 253
                3'b011:  mem_data = 32'hAAAAAA5C;  // address 254
                3'b100:  mem_data = 32'h0F0F0FC3;  // address 255
                default: mem_data = 32'h55555599;  // program memory
            endcase
        end

        exception_sequencer #(.MEM_LATENCY(L), .PC_INC(4)) u_dut (
            .clk         (clk),
            .reset       (rst_a[gi]),
            .exc_noop    (noop_a[gi]),
            .exc_overflow(ovf_a[gi]),
            .exc_div0    (div0_a[gi]),
            .pc_cur      (pc_a[gi]),
            .mem_data_out(mem_data),
            .src_add_mem (src_a[gi]),
            .busy        (busy_a[gi]),
            .epc_write   (epcw_a[gi]),
            .epc_value   (epcv_a[gi]),
            .pc_write    (pcw_a[gi]),
            .pc_value    (pcv_a[gi]),
            .exc_cause   (cause_a[gi]),
            .done        (done_a[gi])
        );
    end

    // ---------------------------------------------------------------- monitor
    task automatic chk(input string name, input int i,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%h required=%h", name, i, act, req);
        end
    endtask

    initial begin : monitor
        int busy_len [3];
        int idle_cnt [3];
        bit saw_epc  [3];
        bit saw_pc   [3];
        bit pend_rst [3];
        int cycles;
        bit has;
        cycles = 0;
        for (int i = 0; i < 3; i++) begin
            busy_len[i] = 0; idle_cnt[i] = 0;
            saw_epc[i] = 0; saw_pc[i] = 0; pend_rst[i] = 0;
        end
        forever begin
            @(negedge clk);
            cycles++;
            for (int i = 0; i < 3; i++) begin
                // First cycle after a reset edge: everything must be zero.
                if (pend_rst[i]) begin
                    chk("rst_busy", i, 32'(busy_a[i]), 32'd0);
                    chk("rst_src", i, 32'(src_a[i]), 32'd0);
                    chk("rst_cause", i, 32'(cause_a[i]), 32'd0);
                    chk("rst_pc_write", i, 32'(pcw_a[i]), 32'd0);
                    chk("rst_epc_write", i, 32'(epcw_a[i]), 32'd0);
                    chk("rst_done", i, 32'(done_a[i]), 32'd0);
                    chk("rst_epc_value", i, epcv_a[i], 32'd0);
                    chk("rst_pc_value", i, pcv_a[i], 32'd0);
                end
                has = (q.size() > 0) && (q[0].inst == i);
                if (busy_a[i]) begin
                    busy_len[i]++;
                    chk("busy_owner", i, 32'(has), 32'd1);
                    if (has) chk("src_busy", i, 32'(src_a[i]), 32'(code_of(q[0].cause)));
                end else begin
                    chk("src_idle", i, 32'(src_a[i]), 32'd0);
                    if (!done_a[i]) begin
                        busy_len[i] = 0;
                        idle_cnt[i]++;
                    end
                end
                if (epcw_a[i] || pcw_a[i])
                    chk("strobe_overlap", i, 32'(epcw_a[i] & pcw_a[i]), 32'd0);
                if (epcw_a[i]) begin
                    chk("epc_expected", i, 32'(has), 32'd1);
                    chk("epc_once", i, 32'(saw_epc[i]), 32'd0);
                    if (has) begin
                        chk("epc_value", i, epcv_a[i], q[0].epc);
                        chk("epc_cause", i, 32'(cause_a[i]), 32'(q[0].cause));
                        if (q[0].gap >= 0) chk("idle_gap", i, idle_cnt[i], q[0].gap);
                    end
                    saw_epc[i] = 1'b1;
                end
                if (pcw_a[i]) begin
                    chk("pc_expected", i, 32'(has), 32'd1);
                    chk("pc_once", i, 32'(saw_pc[i]), 32'd0);
                    chk("pc_after_epc", i, 32'(saw_epc[i]), 32'd1);
                    if (has) chk("pc_value", i, pcv_a[i], q[0].pcv);
                    saw_pc[i] = 1'b1;
                end
                if (done_a[i]) begin
                    chk("done_expected", i, 32'(has), 32'd1);
                    chk("done_after_pc", i, 32'(saw_pc[i]), 32'd1);
                    chk("busy_len", i, busy_len[i], lat_of(i) + 2);
                    if (has) begin
                        chk("done_cause", i, 32'(cause_a[i]), 32'(q[0].cause));
                        $display("txn inst=%0d cause=%0d epc=%h pc=%h busy=%0d",
                                 i, cause_a[i], q[0].epc, q[0].pcv, busy_len[i]);
                        void'(q.pop_front());
                    end
                    saw_epc[i] = 1'b0;
                    saw_pc[i]  = 1'b0;
                    idle_cnt[i] = 0;
                end
                // A reset seen this cycle aborts whatever sequence is pending.
                if (rst_a[i]) begin
                    if (has && saw_epc[i]) void'(q.pop_front());
                    saw_epc[i] = 1'b0;
                    saw_pc[i]  = 1'b0;
                    busy_len[i] = 0;
                    idle_cnt[i] = 0;
                end
                pend_rst[i] = rst_a[i];
            end
            if (stim_done || cycles > 20000) begin
                chk("watchdog", 0, 32'(cycles > 20000), 32'd0);
                chk("queue_drained", 0, 32'(q.size()), 32'd0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input int i, input logic [1:0] c,
                              input logic [31:0] epc, input logic [31:0] pcv,
                              input int gap);
        exp_t e;
        e.inst = i; e.cause = c; e.epc = epc; e.pcv = pcv; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic pulse(input int i, input logic n, input logic o,
                         input logic d, input logic [31:0] pc);
        pc_a[i] = pc; noop_a[i] = n; ovf_a[i] = o; div0_a[i] = d;
        tick();
        noop_a[i] = 1'b0; ovf_a[i] = 1'b0; div0_a[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1; noop_a[i] = 1'b0; ovf_a[i] = 1'b0;
            div0_a[i] = 1'b0; pc_a[i] = 32'd0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
        tick();

        // MEM_LATENCY = 2
        expect_seq(0, 2'd2, 32'h000000FC, 32'h0000005C, -1);   // overflow
        pulse(0, 1'b0, 1'b1, 1'b0, 32'h00000100);
        drain();

        expect_seq(0, 2'd3, 32'h00001FFC, 32'h000000C3, -1);   // all three
        pulse(0, 1'b1, 1'b1, 1'b1, 32'h00002000);
        drain();

        expect_seq(0, 2'd1, 32'hFFFFFFFC, 32'h00000011, -1);   // noop, pc 0
        pulse(0, 1'b1, 1'b0, 1'b0, 32'h00000000);
        drain();

        expect_seq(0, 2'd3, 32'h0000003C, 32'h000000C3, -1);   // div0 again in WAIT
        pulse(0, 1'b0, 1'b0, 1'b1, 32'h00000040);
        tick();
        pulse(0, 1'b0, 1'b0, 1'b1, 32'h00000999);
        drain();

        // div0 held: three back-to-back sequences, one IDLE cycle apart
        expect_seq(0, 2'd3, 32'h0000007C, 32'h000000C3, -1);
        expect_seq(0, 2'd3, 32'h0000007C, 32'h000000C3, 1);
        expect_seq(0, 2'd3, 32'h0000007C, 32'h000000C3, 1);
        pc_a[0] = 32'h00000080;
        div0_a[0] = 1'b1;
        repeat (15) tick();
        div0_a[0] = 1'b0;
        drain();

        // reset during WAIT aborts with no pc_write
        expect_seq(0, 2'd3, 32'h000004FC, 32'h000000C3, -1);
        pulse(0, 1'b0, 1'b0, 1'b1, 32'h00000500);
        tick();
        rst_a[0] = 1'b1;
        tick();
        rst_a[0] = 1'b0;
        repeat (4) tick();

        expect_seq(0, 2'd2, 32'h00000200, 32'h0000005C, -1);   // recovery
        pulse(0, 1'b0, 1'b1, 1'b0, 32'h00000204);
        drain();

        // MEM_LATENCY = 1
        expect_seq(1, 2'd2, 32'h000002FC, 32'h0000005C, -1);
        pulse(1, 1'b0, 1'b1, 1'b0, 32'h00000300);
        drain();
        expect_seq(1, 2'd3, 32'h0000000C, 32'h000000C3, -1);
        pulse(1, 1'b0, 1'b0, 1'b1, 32'h00000010);
        drain();

        // MEM_LATENCY = 5
        expect_seq(2, 2'd1, 32'h00001000, 32'h00000011, -1);
        pulse(2, 1'b1, 1'b0, 1'b0, 32'h00001004);
        drain();
        expect_seq(2, 2'd2, 32'h00000004, 32'h0000005C, -1);
        pulse(2, 1'b0, 1'b1, 1'b0, 32'h00000008);
        drain();

        stim_done = 1'b1;
    end

endmodule
